// File: rtl/calc_entry_driver_if.sv
// Bus between the entry driver, its host/test source and the calculator core.
// The master side is the driver itself; the slave side is the surrounding
// environment (host writes/commands plus the calculator's switch/button/LED pins).
interface calc_entry_driver_if #(
  parameter int DEPTH = 16
) ();
  // Host side
  logic                       wr_en;
  logic [7:0]                 wr_data;
  logic                       clear;
  logic                       start;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       full;
  logic                       busy;
  logic                       done;
  logic [7:0]                 res_sum;
  logic [7:0]                 res_avg;
  logic [7:0]                 res_sumsq;
  logic [7:0]                 res_std;
  logic                       res_valid;
  // Calculator side
  logic [7:0]                 sw_out;
  logic                       btnc_out;
  logic                       btnr_out;
  logic [7:0]                 led_in;

  modport master (
    input  wr_en, wr_data, clear, start, led_in,
    output count, full, busy, done, sw_out, btnc_out, btnr_out,
           res_sum, res_avg, res_sumsq, res_std, res_valid
  );

  modport slave (
    output wr_en, wr_data, clear, start, led_in,
    input  count, full, busy, done, sw_out, btnc_out, btnr_out,
           res_sum, res_avg, res_sumsq, res_std, res_valid
  );
endinterface

// File: rtl/calc_entry_driver.sv
// Replays buffered operands onto the calculator's switch/button entry
// protocol (count, then each value, via btnc), then issues four btnr
// readbacks and captures the LED response into result registers.
module calc_entry_driver #(
  parameter int DEPTH  = 16,
  parameter int SETUP  = 4,
  parameter int PULSE  = 8,
  parameter int GAP    = 8,
  parameter int SETTLE = 4
) (
  input logic                 clk,
  input logic                 rst,
  calc_entry_driver_if.master bus
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int KW   = $clog2(DEPTH + 5);
  localparam int MAXP = (SETUP > PULSE) ? ((SETUP > GAP) ? SETUP : GAP)
                                        : ((PULSE > GAP) ? PULSE : GAP);
  localparam int PW   = $clog2(MAXP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [KW-1:0]   k, k_nx, k_inc, count_k;
  logic [PW-1:0]   phase, phase_nx;
  logic [7:0]      sw_q, sw_nx, next_item;
  logic            btnc_q, btnr_q, busy_q, done_q;
  logic [CW-1:0]   count_q, count_nx;
  logic            full_q;
  logic [7:0]      res_sum_q, res_avg_q, res_sumsq_q, res_std_q;
  logic            res_valid_q;
  logic [7:0]      buffer [DEPTH];

  logic            is_readback, last_item, start_ok, wr_ok, sample_led, clear_ok;
  logic [1:0]      rb_sel;

  // Item bookkeeping: which item k is, and what the following item presents
  assign count_k     = KW'(count_q);
  assign k_inc       = k + KW'(1);
  assign is_readback = (k > count_k);
  assign last_item   = (k == count_k + KW'(4));
  assign rb_sel      = 2'(k - count_k - KW'(1));

  // Commands are only honoured in IDLE; clear beats start, start beats a write
  // so the count shown on sw_out matches the count being replayed.
  assign clear_ok   = (state == S_IDLE) && bus.clear;
  assign start_ok   = (state == S_IDLE) && bus.start && (count_q != '0) && !bus.clear;
  assign wr_ok      = (state == S_IDLE) && bus.wr_en && !bus.clear && !full_q && !start_ok;
  assign sample_led = (state == S_PULSE) && is_readback && (phase == PW'(SETTLE - 1));

  // Switch value for item k+1: an operand or a readback selector
  always_comb begin
    next_item = 8'd0;
    if (k_inc <= count_k) next_item = buffer[AW'(k_inc - KW'(1))];
    else                  next_item = {6'b0, 2'(k_inc - count_k - KW'(1))};
  end

  // Next-state logic for the replay sequencer
  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    phase_nx = phase + PW'(1);
    sw_nx    = sw_q;
    unique case (state)
      S_IDLE: begin
        phase_nx = '0;
        if (start_ok) begin
          state_nx = S_SETUP;
          k_nx     = '0;
          sw_nx    = 8'(count_q);
        end
      end
      S_SETUP: begin
        if (phase == PW'(SETUP - 1)) begin
          state_nx = S_PULSE;
          phase_nx = '0;
        end
      end
      S_PULSE: begin
        if (phase == PW'(PULSE - 1)) begin
          state_nx = S_GAP;
          phase_nx = '0;
        end
      end
      S_GAP: begin
        if (phase == PW'(GAP - 1)) begin
          phase_nx = '0;
          if (last_item) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_SETUP;
            k_nx     = k_inc;
            sw_nx    = next_item;
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        phase_nx = '0;
      end
      default: begin
        state_nx = S_IDLE;
        phase_nx = '0;
      end
    endcase
  end

  // Next operand count
  always_comb begin
    count_nx = count_q;
    if (clear_ok)   count_nx = '0;
    else if (wr_ok) count_nx = count_q + CW'(1);
  end

  // State register; outputs are registered from the next state so they line
  // up exactly with the state they describe.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      k      <= '0;
      phase  <= '0;
      sw_q   <= '0;
      btnc_q <= 1'b0;
      btnr_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      k      <= k_nx;
      phase  <= phase_nx;
      sw_q   <= sw_nx;
      // PULSE is only entered from SETUP, so k is already the pulsing item
      btnc_q <= (state_nx == S_PULSE) && !is_readback;
      btnr_q <= (state_nx == S_PULSE) && is_readback;
      busy_q <= (state_nx == S_SETUP) || (state_nx == S_PULSE) || (state_nx == S_GAP);
      done_q <= (state_nx == S_DONE);
    end
  end

  // Operand storage
  // NOTE: the buffer is deliberately left without reset; count gates every
  // read, so stale contents are never observed and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) buffer[AW'(count_q)] <= bus.wr_data;
  end

  // Operand count, full flag and captured readback results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      full_q      <= 1'b0;
      res_sum_q   <= '0;
      res_avg_q   <= '0;
      res_sumsq_q <= '0;
      res_std_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      count_q <= count_nx;
      full_q  <= (count_nx == CW'(DEPTH));
      if (clear_ok || start_ok)  res_valid_q <= 1'b0;
      else if (state_nx == S_DONE) res_valid_q <= 1'b1;
      if (sample_led) begin
        unique case (rb_sel)
          2'd0: res_sum_q   <= bus.led_in;
          2'd1: res_avg_q   <= bus.led_in;
          2'd2: res_sumsq_q <= bus.led_in;
          2'd3: res_std_q   <= bus.led_in;
          default: ;
        endcase
      end
    end
  end

  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sw_out    = sw_q;
  assign bus.btnc_out  = btnc_q;
  assign bus.btnr_out  = btnr_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_avg   = res_avg_q;
  assign bus.res_sumsq = res_sumsq_q;
  assign bus.res_std   = res_std_q;
  assign bus.res_valid = res_valid_q;

endmodule
